// File: rtl/hit_encoder_pkg.sv
// hit_encoder_pkg: shared FSM state encoding for the hit encoder
package hit_encoder_pkg;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
endpackage

// File: rtl/priority_encoder.sv
// priority_encoder: binary index of the lowest set bit of a vector, plus an any-set flag
module priority_encoder #(
    parameter int WIDTH = 16,
    localparam int LOG_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     vector,
    output logic [LOG_WIDTH-1:0] index,
    output logic                 any
);
    // scan from the top down so the lowest set bit is the last one written
    always_comb begin
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) index = vector[i] ? LOG_WIDTH'(i) : index;
    end
    assign any = |vector;
endmodule

// File: rtl/hit_encoder.sv
// hit_encoder: drains a multi-hot hit vector as a stream of binary channel indices, lowest first
module hit_encoder
    import hit_encoder_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int LOG_WIDTH = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_hits,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LOG_WIDTH-1:0] out_index,
    output logic                 out_last,
    output logic [LOG_WIDTH:0]   out_count
);
    logic [0:0]           state;
    logic [WIDTH-1:0]     pending;
    logic [LOG_WIDTH:0]   count_q;
    logic                 pend_any;
    logic                 beat;
    logic                 accept;

    function automatic logic [LOG_WIDTH:0] popcount(input logic [WIDTH-1:0] v);
        logic [LOG_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + {{LOG_WIDTH{1'b0}}, v[i]};
        return c;
    endfunction

    priority_encoder #(.WIDTH(WIDTH)) u_prio (
        .vector(pending),
        .index (out_index),
        .any   (pend_any)
    );

    assign out_valid = state == DRAIN;
    assign out_last  = out_valid & pend_any & ~|(pending & (pending - WIDTH'(1)));
    assign out_count = count_q;
    assign beat      = out_valid & out_ready;
    // completing the last beat frees the slot in the same cycle, so vectors chain without a bubble
    assign in_ready  = (state == IDLE) | (beat & out_last);
    assign accept    = in_valid & in_ready;

    // load a new vector on accept, otherwise retire the lowest pending hit on each output beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            count_q <= '0;
        end else if (accept) begin
            state   <= |in_hits ? DRAIN : IDLE;
            pending <= in_hits;
            count_q <= popcount(in_hits);
        end else if (beat) begin
            state   <= out_last ? IDLE : DRAIN;
            pending <= out_last ? '0 : pending & (pending - WIDTH'(1));
        end
    end
endmodule

// File: tb/tb_hit_encoder.sv
// tb_hit_encoder: directed and randomized checks of hit_encoder against a queue-based reference
module tb_hit_encoder;
    localparam int W = 16;
    localparam int LW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_hits = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [LW-1:0] out_index;
    logic          out_last;
    logic [LW:0]   out_count;

    int total = 0;
    int passed = 0;

    hit_encoder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_hits  (in_hits),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .out_last (out_last),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // reference: the indices still owed for the current vector, plus its popcount
    int  q[$];
    int  mcnt = 0;
    bit  armed = 0;
    bit  mrdy;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            mcnt = 0;
            armed = 1;
        end else begin
            mrdy = (q.size() == 0) || (out_ready && q.size() == 1);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && mrdy) begin
                q.delete();
                mcnt = 0;
                for (int i = 0; i < W; i++) if (in_hits[i]) begin
                    q.push_back(i);
                    mcnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_out_valid", int'(out_valid), int'(q.size() > 0));
            chk("m_in_ready", int'(in_ready), int'(q.size() == 0 || (out_ready && q.size() == 1)));
            chk("m_out_index", int'(out_index), q.size() > 0 ? q[0] : 0);
            chk("m_out_last", int'(out_last), int'(q.size() == 1));
            chk("m_out_count", int'(out_count), mcnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic beat_chk(input string name, input int idx, input int last, input int cnt);
        look();
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_index"}, int'(out_index), idx);
        chk({name, "_last"}, int'(out_last), last);
        chk({name, "_count"}, int'(out_count), cnt);
    endtask

    int exp1[4] = '{0, 5, 10, 15};
    bit acc;

    initial begin
        repeat (2) tick();
        look();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_count", int'(out_count), 0);
        tick();
        rst = 1'b0;

        in_valid = 1'b1; in_hits = 16'h8421; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat_chk("t1", exp1[i], int'(i == 3), 4);
            tick();
        end
        look();
        chk("t1_idle", int'(out_valid), 0);

        tick();
        in_valid = 1'b1; in_hits = 16'h0003; out_ready = 1'b0;
        tick();
        in_hits = 16'hA5A5;
        for (int i = 0; i < 3; i++) begin
            beat_chk("t2_hold", 0, 0, 2);
            chk("t2_hold_in_ready", int'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        beat_chk("t2_b0", 0, 0, 2);
        tick();
        beat_chk("t2_b1", 1, 1, 2);
        tick();
        look();
        chk("t2_idle", int'(out_valid), 0);

        tick();
        in_valid = 1'b1; in_hits = 16'h0000;
        look();
        chk("t3_zero_ready", int'(in_ready), 1);
        tick();
        in_hits = 16'h0010;
        look();
        chk("t3_no_beat", int'(out_valid), 0);
        chk("t3_ready", int'(in_ready), 1);
        chk("t3_count0", int'(out_count), 0);
        tick();
        in_valid = 1'b0;
        beat_chk("t3", 4, 1, 1);
        tick();

        in_valid = 1'b1; in_hits = 16'h0006;
        tick();
        in_hits = 16'h0100;
        beat_chk("t4_b0", 1, 0, 2);
        chk("t4_b0_ready", int'(in_ready), 0);
        tick();
        beat_chk("t4_b1", 2, 1, 2);
        chk("t4_b1_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        beat_chk("t4_b2", 8, 1, 1);
        tick();

        in_valid = 1'b1; in_hits = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            beat_chk("t5", i, int'(i == 15), 16);
            tick();
        end
        look();
        chk("t5_idle", int'(out_valid), 0);

        in_valid = 1'b1; in_hits = 16'hF000;
        tick();
        in_valid = 1'b0;
        beat_chk("t6_b0", 12, 0, 4);
        tick();
        beat_chk("t6_b1", 13, 0, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        look();
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_ready", int'(in_ready), 1);
        chk("t6_rst_count", int'(out_count), 0);
        tick();
        look();
        chk("t6_no_tail", int'(out_valid), 0);

        for (int n = 0; n < 3000; n++) begin
            look();
            acc = in_valid && in_ready;
            tick();
            rst = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!(in_valid && !acc)) begin
                in_valid = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 4))
                    0: in_hits = '0;
                    1: in_hits = W'(1) << $urandom_range(0, W - 1);
                    2: in_hits = W'($urandom());
                    3: in_hits = '1;
                    default: in_hits = W'($urandom() & $urandom() & $urandom());
                endcase
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
